// File: rtl/top2_pkg.sv
// rtl/top2_pkg.sv - shared types, defaults and round-robin pick for the top-2 frame scheduler
package top2_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W_DEF      = 16;
  localparam int MAX_REQ        = 32;
  localparam int IDX_W          = 5;

  typedef enum logic [1:0] {ARB, STREAM, DRAIN, RESULT} state_t;

  // First asserted valid bit at or after ptr, wrapping within n requesters.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                               input int unsigned ptr,
                                               input int unsigned n);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = IDX_W'(ptr);
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = IDX_W'((ptr + k) % n);
      if (k < n && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/top2_frame_sched_tracker.sv
// rtl/top2_frame_sched_tracker.sv - streaming largest/second-largest tracker with saturating beat count
// TOP2_DISTINCT_EN: second-largest excludes duplicates of the current max.
module top2_tracker
  import top2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [DATA_WIDTH-1:0] second_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] max_q;
  logic [DATA_WIDTH-1:0] second_q;
  logic [CNT_W-1:0]      count_q;
  logic                  sec_upd;

`ifdef TOP2_DISTINCT_EN
  assign sec_upd = (din_i > second_q) && (din_i != max_q);
`else
  assign sec_upd = din_i > second_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q    <= '0;
      second_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      max_q    <= '0;
      second_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      if (din_i > max_q) begin
        second_q <= max_q;
        max_q    <= din_i;
      end else if (sec_upd) begin
        second_q <= din_i;
      end
      if (count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign max_o    = max_q;
  assign second_o = second_q;
  assign count_o  = count_q;

endmodule

// File: rtl/top2_frame_sched.sv
// rtl/top2_frame_sched.sv - round-robin frame arbiter sharing one top-2 tracker among N_REQ requesters
// TOP2_DISTINCT_EN selects distinct-value second-largest inside the tracker.
module top2_frame_sched
  import top2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_REQ      = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            in_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [N_REQ-1:0]            in_last,
  output logic [N_REQ-1:0]            in_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(N_REQ)-1:0]    res_id,
  output logic [DATA_WIDTH-1:0]       res_max,
  output logic [DATA_WIDTH-1:0]       res_second,
  output logic [CNT_W-1:0]            res_count
);

  localparam int ID_W = $clog2(N_REQ);

  state_t                state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       g_q;
  logic [ID_W-1:0]       g_d;
  logic [N_REQ-1:0]      in_ready_q;
  logic                  res_valid_q;
  logic [ID_W-1:0]       res_id_q;
  logic [DATA_WIDTH-1:0] res_max_q;
  logic [DATA_WIDTH-1:0] res_second_q;
  logic [CNT_W-1:0]      res_count_q;

  logic [MAX_REQ-1:0]    valid_ext;
  logic [DATA_WIDTH-1:0] din;
  logic                  beat;
  logic [DATA_WIDTH-1:0] trk_max;
  logic [DATA_WIDTH-1:0] trk_second;
  logic [CNT_W-1:0]      trk_count;

  assign valid_ext = MAX_REQ'(in_valid);
  assign g_d       = ID_W'(rr_pick(valid_ext, 32'(ptr_q), N_REQ));
  assign din       = in_data[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
  assign beat      = (state_q == STREAM) && in_valid[g_q] && in_ready_q[g_q];

  top2_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ARB),
    .en_i     (beat),
    .din_i    (din),
    .max_o    (trk_max),
    .second_o (trk_second),
    .count_o  (trk_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      g_q          <= '0;
      in_ready_q   <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_max_q    <= '0;
      res_second_q <= '0;
      res_count_q  <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (|in_valid) begin
            g_q        <= g_d;
            in_ready_q <= N_REQ'(1) << g_d;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (beat && in_last[g_q]) begin
            in_ready_q <= '0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: state_q <= RESULT;
        RESULT: begin
          // First RESULT cycle latches the settled tracker; then wait for the consumer.
          if (!res_valid_q) begin
            res_valid_q  <= 1'b1;
            res_id_q     <= g_q;
            res_max_q    <= trk_max;
            res_second_q <= trk_second;
            res_count_q  <= trk_count;
          end else if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= (g_q == ID_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
            state_q     <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_max    = res_max_q;
  assign res_second = res_second_q;
  assign res_count  = res_count_q;

endmodule

// File: doc/top2_frame_sched.md
Name: top2_frame_sched

Overview:
- Shares one streaming top-2 tracker (largest and second-largest value) between N_REQ requesters.
- Each requester submits a frame of samples with a valid/ready/last handshake.
- Frames are granted round-robin; a granted frame runs to completion before the next grant.
- After each frame, one result beat goes out: requester ID, largest, second-largest, beat count.

Parameters:
- DATA_WIDTH, 32, sample width in bits
- N_REQ, 4, number of requesters (>=2)
- CNT_W, 16, width of frame beat counter (saturating)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  N_REQ  per-requester sample valid
- in_data  in  N_REQ*DATA_WIDTH  flattened samples; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  N_REQ  marks the final sample of a frame
- in_ready  out  N_REQ  per-requester accept; at most one bit high
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  $clog2(N_REQ)  requester that owned the frame
- res_max  out  DATA_WIDTH  largest sample of the frame
- res_second  out  DATA_WIDTH  second-largest sample of the frame
- res_count  out  CNT_W  accepted beats in the frame, saturating at all-ones

Behaviour:
- Reset (async, rst=0):
  - state=ARB, rr pointer=0
  - in_ready=0, res_valid=0, res_id/res_max/res_second/res_count=0
  - tracker max/second=0
  - Reset mid-frame abandons the frame; no result is emitted.
- FSM states: ARB, STREAM, DRAIN, RESULT.
- ARB:
  - Scan in_valid starting at the rr pointer, wrapping.
  - First asserted index becomes grant g.
  - Tracker is cleared (max=0, second=0, count=0).
  - Go to STREAM next cycle.
  - If no in_valid, stay in ARB. in_ready=0 throughout.
- STREAM:
  - in_ready[g]=1, all other bits 0.
  - A beat is accepted when in_valid[g] && in_ready[g].
  - The tracker registers each accepted beat at the next edge.
  - Accepted beat with in_last[g]=1 -> DRAIN; in_ready drops in the same cycle the state changes.
- DRAIN: one cycle for the final tracker update to settle, then go to RESULT.
- RESULT:
  - res_valid=1; res_* are registered and stable while res_valid && !res_ready.
  - On res_ready: rr pointer = (g+1) mod N_REQ, go to ARB.
- Latency:
  - last beat accepted at edge T -> res_valid high after edge T+2.
  - Minimum 2 idle cycles (RESULT handshake + ARB) between frames.
- Tracker update on accepted d (unsigned compare):
  - d > max: second<=max, max<=d
  - else if d > second: second<=d
  - Duplicates of max therefore set second=max.
  - count<=count+1, saturating.
- Boundary cases:
  - Single-beat frame: second=0, count=1.
  - Requesters not granted wait; valid may remain asserted indefinitely.
  - Zero-length frames are impossible (last accompanies data).
  - Pointer wrap is N_REQ-1 -> 0.

Optional Feature:
- Macro TOP2_DISTINCT_EN.
- Defined: second-largest is the largest value strictly less than max. The update condition for second becomes d > second && d != max; duplicates of max are ignored for second.
- Undefined: duplicates count, as above.

Decomposition:
- Package top2_pkg holds:
  - typedef enum state_t {ARB, STREAM, DRAIN, RESULT}
  - the function rr_pick(valid, ptr) returning the grant index
  - localparam defaults for DATA_WIDTH/CNT_W
- Sub-module top2_tracker (clk, rst, clr, en, din -> max, second, count) holds the compare/update logic and the TOP2_DISTINCT_EN switch.
- The top level holds the FSM, arbitration and muxing.

Test Plan:
- Requester 0 frame 3,9,4,7(last), res_ready=1 -> res_id=0, max=9, second=7, count=4; res_valid exactly 2 cycles after last beat.
- Frame 5,5(last) -> max=5, second=5; with TOP2_DISTINCT_EN -> max=5, second=0.
- Requesters 0,1,3 all valid continuously, one-beat frames -> grant order 0,1,3,0,1,3; in_ready never has more than one bit high.
- res_ready held low 5 cycles during RESULT -> res_* stable, res_valid stays 1, all in_ready=0; next grant only after the handshake.
- Single-beat frame 42 from requester 2 -> max=42, second=0, count=1, res_id=2.
- rst pulsed low mid-frame after 2 beats -> all outputs 0 immediately; no result for that frame; first grant after reset goes to lowest valid index from pointer 0.
